// File: rtl/csr_write_sequencer_pkg.sv
// ============================================================================
//  Module      : CSR_PROPS (package)
//  Description : CSR opcodes, sequencer states, mstatus bit positions and the
//                architectural-address to internal-index map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package CSR_PROPS;

    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_INST     = 3'd2,
        ST_T_EPC    = 3'd3,
        ST_T_CAUSE  = 3'd4,
        ST_T_TVAL   = 3'd5,
        ST_T_STATUS = 3'd6
    } seq_state_e;

    typedef enum logic [11:0] {
        CSR_SSTATUS  = 12'h100,
        CSR_SSCRATCH = 12'h140,
        CSR_SEPC     = 12'h141,
        CSR_SCAUSE   = 12'h142,
        CSR_STVAL    = 12'h143,
        CSR_MSTATUS  = 12'h300,
        CSR_MSCRATCH = 12'h340,
        CSR_MEPC     = 12'h341,
        CSR_MCAUSE   = 12'h342,
        CSR_MTVAL    = 12'h343
    } csr_addr_e;

    localparam int c_mstatus_sie    = 1;
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_spie   = 5;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_spp    = 8;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    // sstatus is a restricted view of mstatus, so both share one entry.
    function automatic logic [7:0] internal_idx(input csr_addr_e addr);
        logic [7:0] idx;
        case (addr)
            CSR_MSTATUS,
            CSR_SSTATUS:  idx = 8'h00;
            CSR_MSCRATCH: idx = 8'h10;
            CSR_MEPC:     idx = 8'h11;
            CSR_MCAUSE:   idx = 8'h12;
            CSR_MTVAL:    idx = 8'h13;
            CSR_SSCRATCH: idx = 8'h20;
            CSR_SEPC:     idx = 8'h21;
            CSR_SCAUSE:   idx = 8'h22;
            CSR_STVAL:    idx = 8'h23;
            default:      idx = 8'hFF;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_write_sequencer_if.sv
// ============================================================================
//  Module      : csr_write_sequencer_if
//  Description : Init source, register-file port and requester handshakes of
//                the CSR write sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_write_sequencer_if #(
    parameter int IDX_W = 8,
    parameter int XLEN  = 64
);
    import CSR_PROPS::*;

    logic [IDX_W-1:0] init_idx;
    logic [XLEN-1:0]  init_data;
    logic             init_done;

    logic [IDX_W-1:0] rd_idx;
    logic [XLEN-1:0]  rd_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;

    logic             inst_valid;
    logic             inst_ready;
    logic [IDX_W-1:0] inst_idx;
    csr_op_e          inst_op;
    logic [XLEN-1:0]  inst_wdata;
    logic             inst_rsp_valid;
    logic [XLEN-1:0]  inst_rsp_rdata;

    logic             trap_valid;
    logic             trap_ready;
    logic             trap_to_s;
    logic [1:0]       trap_priv;
    logic [XLEN-1:0]  trap_cause;
    logic [XLEN-1:0]  trap_epc;
    logic [XLEN-1:0]  trap_tval;
    logic             trap_done;

    modport slave (
        input  init_data, rd_data,
        input  inst_valid, inst_idx, inst_op, inst_wdata,
        input  trap_valid, trap_to_s, trap_priv, trap_cause, trap_epc, trap_tval,
        output init_idx, init_done, rd_idx, wr_en, wr_idx, wr_data,
        output inst_ready, inst_rsp_valid, inst_rsp_rdata,
        output trap_ready, trap_done
    );

    modport master (
        output init_data, rd_data,
        output inst_valid, inst_idx, inst_op, inst_wdata,
        output trap_valid, trap_to_s, trap_priv, trap_cause, trap_epc, trap_tval,
        input  init_idx, init_done, rd_idx, wr_en, wr_idx, wr_data,
        input  inst_ready, inst_rsp_valid, inst_rsp_rdata,
        input  trap_ready, trap_done
    );

endinterface

`default_nettype wire

// File: rtl/csr_write_sequencer.sv
// ============================================================================
//  Module      : csr_write_sequencer
//  Description : Sole writer of the internal CSR file: reset sweep, then
//                arbitration between CSR instructions and trap-entry commits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_write_sequencer
    import CSR_PROPS::*;
#(
    parameter int IDX_W = 8,
    parameter int XLEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_write_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_mstatus_idx = IDX_W'(internal_idx(CSR_MSTATUS));
    localparam logic [IDX_W-1:0] c_mepc_idx    = IDX_W'(internal_idx(CSR_MEPC));
    localparam logic [IDX_W-1:0] c_mcause_idx  = IDX_W'(internal_idx(CSR_MCAUSE));
    localparam logic [IDX_W-1:0] c_mtval_idx   = IDX_W'(internal_idx(CSR_MTVAL));
    localparam logic [IDX_W-1:0] c_sepc_idx    = IDX_W'(internal_idx(CSR_SEPC));
    localparam logic [IDX_W-1:0] c_scause_idx  = IDX_W'(internal_idx(CSR_SCAUSE));
    localparam logic [IDX_W-1:0] c_stval_idx   = IDX_W'(internal_idx(CSR_STVAL));

    seq_state_e       r_state;
    seq_state_e       w_next_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_init_done;

    logic [IDX_W-1:0] r_idx;
    csr_op_e          r_op;
    logic [XLEN-1:0]  r_wdata;
    logic             r_to_s;
    logic [1:0]       r_priv;
    logic [XLEN-1:0]  r_cause;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_tval;

    logic             w_inst_hs;
    logic             w_trap_hs;
    logic [XLEN-1:0]  w_inst_new;

    function automatic logic [XLEN-1:0] trap_mstatus(
        input logic [XLEN-1:0] old,
        input logic            to_s,
        input logic [1:0]      priv
    );
        logic [XLEN-1:0] v;
        v = old;
        if (to_s) begin
            v[c_mstatus_spie] = old[c_mstatus_sie];
            v[c_mstatus_sie]  = 1'b0;
            v[c_mstatus_spp]  = priv[0];
        end else begin
            v[c_mstatus_mpie] = old[c_mstatus_mie];
            v[c_mstatus_mie]  = 1'b0;
            v[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = priv;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + IDX_W'(1);
                if (r_cnt == '1) begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // Request fields are held only for the duration of one operation.
    always_ff @(posedge clk) begin
        if (w_trap_hs) begin
            r_to_s  <= bus.trap_to_s;
            r_priv  <= bus.trap_priv;
            r_cause <= bus.trap_cause;
            r_epc   <= bus.trap_epc;
            r_tval  <= bus.trap_tval;
        end else if (w_inst_hs) begin
            r_idx   <= bus.inst_idx;
            r_op    <= bus.inst_op;
            r_wdata <= bus.inst_wdata;
        end
    end

    always_comb begin
        case (r_op)
            CSR_RS:  w_inst_new = bus.rd_data | r_wdata;
            CSR_RC:  w_inst_new = bus.rd_data & ~r_wdata;
            default: w_inst_new = r_wdata;
        endcase
    end

    assign bus.init_idx  = r_cnt;
    assign bus.init_done = r_init_done;

    // rst overrides every state so an aborted operation never writes or responds.
    always_comb begin
        w_next_state       = r_state;
        w_inst_hs          = 1'b0;
        w_trap_hs          = 1'b0;
        bus.rd_idx         = '0;
        bus.wr_en          = 1'b0;
        bus.wr_idx         = '0;
        bus.wr_data        = '0;
        bus.inst_ready     = 1'b0;
        bus.inst_rsp_valid = 1'b0;
        bus.inst_rsp_rdata = '0;
        bus.trap_ready     = 1'b0;
        bus.trap_done      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_INIT: begin
                    bus.wr_en   = 1'b1;
                    bus.wr_idx  = r_cnt;
                    bus.wr_data = bus.init_data;
                    if (r_cnt == '1) begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    bus.trap_ready = 1'b1;
                    bus.inst_ready = !bus.trap_valid;
                    if (bus.trap_valid) begin
                        w_trap_hs    = 1'b1;
                        w_next_state = ST_T_EPC;
                    end else if (bus.inst_valid) begin
                        w_inst_hs    = 1'b1;
                        w_next_state = ST_INST;
                    end
                end
                ST_INST: begin
                    bus.rd_idx         = r_idx;
                    bus.wr_idx         = r_idx;
                    bus.wr_data        = w_inst_new;
                    bus.wr_en          = !((r_op == CSR_RS || r_op == CSR_RC) && r_wdata == '0);
                    bus.inst_rsp_valid = 1'b1;
                    bus.inst_rsp_rdata = bus.rd_data;
                    w_next_state       = ST_IDLE;
                end
                ST_T_EPC: begin
                    bus.wr_en    = 1'b1;
                    bus.wr_idx   = r_to_s ? c_sepc_idx : c_mepc_idx;
                    bus.wr_data  = r_epc & ~XLEN'(3);
                    w_next_state = ST_T_CAUSE;
                end
                ST_T_CAUSE: begin
                    bus.wr_en    = 1'b1;
                    bus.wr_idx   = r_to_s ? c_scause_idx : c_mcause_idx;
                    bus.wr_data  = r_cause;
                    w_next_state = ST_T_TVAL;
                end
                ST_T_TVAL: begin
                    bus.wr_en    = 1'b1;
                    bus.wr_idx   = r_to_s ? c_stval_idx : c_mtval_idx;
                    bus.wr_data  = r_tval;
                    w_next_state = ST_T_STATUS;
                end
                ST_T_STATUS: begin
                    bus.rd_idx    = c_mstatus_idx;
                    bus.wr_en     = 1'b1;
                    bus.wr_idx    = c_mstatus_idx;
                    bus.wr_data   = trap_mstatus(bus.rd_data, r_to_s, r_priv);
                    bus.trap_done = 1'b1;
                    w_next_state  = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_write_sequencer.sv
// ============================================================================
//  Module      : tb_csr_write_sequencer
//  Description : Scoreboard bench for csr_write_sequencer with a register-file
//                model and hand-computed expected writes and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_write_sequencer;
    import CSR_PROPS::*;

    typedef struct {
        int          cyc;
        logic [7:0]  idx;
        logic [63:0] data;
    } wr_exp_t;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_write_sequencer_if #(.IDX_W(8), .XLEN(64)) bus ();

    csr_write_sequencer #(.IDX_W(8), .XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] mem [256];
    assign bus.init_data = {56'b0, bus.init_idx};
    assign bus.rd_data   = mem[bus.rd_idx];
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_idx] <= bus.wr_data;
    end

    int cyc       = 0;
    int rel_start = -1;
    int checks    = 0;
    int errors    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_exp_t  wq [$];
    rsp_exp_t rq [$];
    int       dq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, compare DUT outputs against the queue heads.
    bit m_ew, m_er, m_ed;
    always @(negedge clk) begin
        m_ew = (wq.size() > 0) && (wq[0].cyc == cyc);
        chk("wr_en", 64'(bus.wr_en), 64'(m_ew));
        if (m_ew) begin
            if (bus.wr_en) begin
                chk("wr_idx", 64'(bus.wr_idx), 64'(wq[0].idx));
                chk("wr_data", bus.wr_data, wq[0].data);
            end
            void'(wq.pop_front());
        end
        m_er = (rq.size() > 0) && (rq[0].cyc == cyc);
        chk("inst_rsp_valid", 64'(bus.inst_rsp_valid), 64'(m_er));
        if (m_er) begin
            if (bus.inst_rsp_valid) chk("inst_rsp_rdata", bus.inst_rsp_rdata, rq[0].data);
            void'(rq.pop_front());
        end
        m_ed = (dq.size() > 0) && (dq[0] == cyc);
        chk("trap_done", 64'(bus.trap_done), 64'(m_ed));
        if (m_ed) void'(dq.pop_front());
        if (!rst && rel_start >= 0) begin
            chk("init_done", 64'(bus.init_done), 64'(cyc - rel_start >= 256));
            if (cyc - rel_start < 256) begin
                chk("inst_ready_init", 64'(bus.inst_ready), 64'd0);
                chk("trap_ready_init", 64'(bus.trap_ready), 64'd0);
            end
        end
    end

    task automatic push_init();
        for (int i = 0; i < 256; i++) begin
            wq.push_back('{cyc: rel_start + i, idx: 8'(i), data: 64'(i)});
        end
    endtask

    task automatic do_inst(input logic [7:0] idx, input csr_op_e op, input logic [63:0] wdata,
                           input logic [63:0] exp_old, input bit exp_we,
                           input logic [63:0] exp_new, output int t);
        int n;
        bus.inst_valid = 1'b1;
        bus.inst_idx   = idx;
        bus.inst_op    = op;
        bus.inst_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!bus.inst_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("inst_accept", 64'(bus.inst_ready), 64'd1);
        t = cyc;
        rq.push_back('{cyc: t + 1, data: exp_old});
        if (exp_we) wq.push_back('{cyc: t + 1, idx: idx, data: exp_new});
        @(posedge clk);
        #1 bus.inst_valid = 1'b0;
    endtask

    task automatic do_trap(input bit to_s, input logic [1:0] priv, input logic [63:0] epc,
                           input logic [63:0] cause, input logic [63:0] tval,
                           input logic [63:0] exp_status, input bit abort, output int t);
        int n;
        bus.trap_valid = 1'b1;
        bus.trap_to_s  = to_s;
        bus.trap_priv  = priv;
        bus.trap_epc   = epc;
        bus.trap_cause = cause;
        bus.trap_tval  = tval;
        n = 0;
        @(negedge clk);
        while (!bus.trap_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("trap_accept", 64'(bus.trap_ready), 64'd1);
        t = cyc;
        wq.push_back('{cyc: t + 1, idx: internal_idx(to_s ? CSR_SEPC : CSR_MEPC),
                       data: epc & ~64'h3});
        if (!abort) begin
            wq.push_back('{cyc: t + 2, idx: internal_idx(to_s ? CSR_SCAUSE : CSR_MCAUSE), data: cause});
            wq.push_back('{cyc: t + 3, idx: internal_idx(to_s ? CSR_STVAL : CSR_MTVAL), data: tval});
            wq.push_back('{cyc: t + 4, idx: internal_idx(CSR_MSTATUS), data: exp_status});
            dq.push_back(t + 4);
        end
        @(posedge clk);
        #1 bus.trap_valid = 1'b0;
    endtask

    initial begin
        int n, t1, t2, tt, ti;
        bus.inst_valid = 1'b0;
        bus.inst_idx   = '0;
        bus.inst_op    = CSR_RW;
        bus.inst_wdata = '0;
        bus.trap_valid = 1'b0;
        bus.trap_to_s  = 1'b0;
        bus.trap_priv  = '0;
        bus.trap_epc   = '0;
        bus.trap_cause = '0;
        bus.trap_tval  = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rel_start = cyc;
        push_init();
        n = 0;
        while (!bus.init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_wait", 64'(bus.init_done), 64'd1);
        @(posedge clk);
        #1;

        // mstatus: MPP=11, MIE=1, SIE=1
        do_inst(internal_idx(CSR_MSTATUS), CSR_RW, 64'h180A, 64'h0, 1'b1, 64'h180A, t1);
        do_inst(internal_idx(CSR_MSCRATCH), CSR_RW, 64'h0F, 64'h10, 1'b1, 64'h0F, t2);
        chk("inst_b2b_accept", 64'(t2), 64'(t1 + 2));
        do_inst(internal_idx(CSR_MSCRATCH), CSR_RS, 64'hF0, 64'h0F, 1'b1, 64'hFF, t1);
        do_inst(internal_idx(CSR_MSCRATCH), CSR_RC, 64'h0F, 64'hFF, 1'b1, 64'hF0, t1);
        do_inst(internal_idx(CSR_MSCRATCH), CSR_RS, 64'h00, 64'hF0, 1'b0, 64'h0, t1);
        do_inst(internal_idx(CSR_MSCRATCH), CSR_RC, 64'h00, 64'hF0, 1'b0, 64'h0, t1);

        // M trap from U: MPIE<-1, MIE<-0, MPP<-00
        do_trap(1'b0, 2'd0, 64'h8000_0003, 64'd2, 64'hDEAD, 64'h82, 1'b0, tt);
        do_inst(internal_idx(CSR_MSTATUS), CSR_RS, 64'h0, 64'h82, 1'b0, 64'h0, ti);
        chk("trap_next_accept", 64'(ti), 64'(tt + 5));
        do_inst(internal_idx(CSR_MEPC), CSR_RS, 64'h0, 64'h8000_0000, 1'b0, 64'h0, t1);

        // S trap from S: SPIE<-1, SIE<-0, SPP<-1
        do_trap(1'b1, 2'd1, 64'h4000_0106, 64'd9, 64'h1234, 64'h1A0, 1'b0, tt);
        do_inst(internal_idx(CSR_SEPC), CSR_RS, 64'h0, 64'h4000_0104, 1'b0, 64'h0, t1);

        // Simultaneous requests: trap from M (MIE=0 so MPIE<-0, MPP<-11) wins
        fork
            do_trap(1'b0, 2'd3, 64'h10, 64'hB, 64'h0, 64'h1920, 1'b0, tt);
            do_inst(internal_idx(CSR_MSTATUS), CSR_RS, 64'h0, 64'h1920, 1'b0, 64'h0, ti);
        join
        chk("arb_inst_accept", 64'(ti), 64'(tt + 5));
        repeat (3) @(posedge clk);
        #1;

        // Reset during T_CAUSE aborts the commit
        do_trap(1'b0, 2'd0, 64'h20, 64'h5, 64'hBEEF, 64'h0, 1'b1, tt);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_mcause", mem[internal_idx(CSR_MCAUSE)], 64'hB);
        chk("abort_mtval", mem[internal_idx(CSR_MTVAL)], 64'h0);
        #1 rst = 1'b0;
        rel_start = cyc;
        push_init();
        repeat (262) @(posedge clk);
        #1;
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
